instr_encoder: RTL and testbench
================================

# instr_encoder

RV32I instruction encoder and issue buffer that drives the `instruction` input of the core's decode controller. It accepts field-level requests (format, func3, alt bit, registers, immediate) over a valid/ready handshake. It packs each request into a 32-bit RV32I word and queues it in a small FIFO. The FIFO head is presented downstream with its own valid/ready handshake. It serves as the stimulus/issue source for controller bring-up and for the multicore test harness.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, 2..16
- `clk` input 1 — single clock, all logic on rising edge
- `reset` input 1 — synchronous, active-high
- `req_valid` input 1 — request present
- `req_ready` output 1 — encoder can accept; `!reset && count != DEPTH`
- `req_type` input 3 — 0 R, 1 I(ALU), 2 L, 3 S, 4 B, 5 U, 6 J, 7 reserved
- `req_func3` input 3 — func3 field
- `req_alt` input 1 — selects func7 = 7'b0100000 (sub/sra/srai)
- `req_rd`, `req_rs1`, `req_rs2` input 5 each — register indices
- `req_imm` input 32 — immediate, byte offset, sign-extended
- `instruction` output 32 — FIFO head word
- `instr_valid` output 1 — FIFO non-empty
- `instr_ready` input 1 — downstream consumes head
- `err` output 1 — one-cycle pulse when a request was rejected
- `count` output $clog2(DEPTH)+1 — occupancy

## Operation
- Accept on `req_valid && req_ready`. The encoded word is written to FIFO tail at that edge.
- Pop on `instr_valid && instr_ready`; the head advances.
- Encodings (opcode per format: R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, U 0110111, J 1101111):
  - R: {func7, rs2, rs1, f3, rd, op}
  - I: {imm[11:0], rs1, f3, rd, op}. For f3 001/101 (shifts): {func7, imm[4:0], rs1, f3, rd, op}.
  - L: {imm[11:0], rs1, f3, rd, op}
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Fields not used by a format are ignored.
- Read/write pointers wrap modulo DEPTH. `count` is updated as +1 / -1 / unchanged.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. This cannot occur when empty, because `instr_valid` is 0. Push is blocked when full.
- Head word order is strictly FIFO.

## Timing
- Reset values: `instruction` 0, `instr_valid` 0, `err` 0, `count` 0, pointers 0, `req_ready` 0 while `reset` is high.
- Latency: accept at edge N into an empty FIFO gives `instr_valid`=1 with the word from cycle N+1.
- Full throughput is one push and one pop per cycle.
- `req_ready` deasserts in the cycle after the edge that makes `count == DEPTH`. It reasserts in the cycle after a pop.
- `err` is registered: it is 1 in the cycle after the rejected accept, then 0.
- Reset mid-operation flushes all entries; `instr_valid` is 0 the next cycle and queued words are lost.

## Configuration
- Macro `INSTR_ENC_LEGAL_CHECK_EN`. When defined, a request is consumed but not enqueued, and `err` pulses, if any of these hold:
  - `req_type` = 7
  - L f3 not in {0,1,2,4,5}
  - S f3 > 2
  - B f3 in {2,3}
  - B/J `imm[0]`=1
  - I/L/S imm not a 12-bit sign-extension
  - B imm outside 13-bit signed range, or J imm outside 21-bit signed range
  - I shift with `imm[31:5]` ≠ 0
  - R `req_alt`=1 with f3 not 000/101
- When undefined: no checks; `err` is tied 0; fields are truncated as per the encodings; `req_type` 7 enqueues 32'h00000013 (nop).

## Test plan
- R: type 0, rd 3, rs1 1, rs2 2, f3 0, alt 0 -> 0x002081B3 one cycle after accept. Same request with alt 1 -> 0x402081B3.
- L: type 2, rd 5, rs1 1, f3 2, imm 8 -> 0x0080A283. B: type 4, rs1 1, rs2 2, f3 0, imm -4 -> 0xFE208EE3.
- J: type 6, rd 1, imm 2048 -> 0x001000EF. Back-to-back with U (rd 7, imm 0x12345000 -> 0x123453B7): words emerge in order on consecutive cycles with `instr_ready`=1.
- DEPTH 4, `instr_ready`=0, push 5 requests -> `count`=4, `req_ready`=0, 5th not accepted. Then `instr_ready`=1 -> 4 words in push order, `count` 0.
- Macro defined: L with f3 3 -> `err`=1 one cycle later, `count` unchanged. Macro undefined: same request enqueues 0x...3083 (f3 3), `err` 0.
- Three words queued, assert `reset` one cycle -> `count` 0, `instr_valid` 0, `instruction` 0 next cycle. A new request then appears one cycle after accept.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field-level request encoder feeding a small issue FIFO toward the decode controller.
// Optional legality screening is enabled by defining INSTR_ENC_LEGAL_CHECK_EN.
module instr_encoder #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [2:0]               req_type,
   input  logic [2:0]               req_func3,
   input  logic                     req_alt,
   input  logic [4:0]               req_rd,
   input  logic [4:0]               req_rs1,
   input  logic [4:0]               req_rs2,
   input  logic [31:0]              req_imm,
   output logic [31:0]              instruction,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic                     err,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_B = 7'b1100011;
   localparam logic [6:0] OP_U = 7'b0110111;
   localparam logic [6:0] OP_J = 7'b1101111;
   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic [31:0] encode(
      input logic [2:0]  t,
      input logic [2:0]  f3,
      input logic        alt,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [31:0] imm
   );
      logic [6:0]  f7;
      logic [31:0] w;
      f7 = alt ? 7'b0100000 : 7'b0000000;
      case (t)
         3'd0: w = {f7, rs2, rs1, f3, rd, OP_R};
         3'd1: begin
            // Shift-immediates carry func7 in the upper immediate bits.
            if (f3 == 3'b001 || f3 == 3'b101)
               w = {f7, imm[4:0], rs1, f3, rd, OP_I};
            else
               w = {imm[11:0], rs1, f3, rd, OP_I};
         end
         3'd2: w = {imm[11:0], rs1, f3, rd, OP_L};
         3'd3: w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
         3'd4: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
         3'd5: w = {imm[31:12], rd, OP_U};
         3'd6: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
         default: w = NOP;
      endcase
      return w;
   endfunction

   logic [31:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]  count_q, count_d;
   logic         accept, push, pop, illegal;
   logic [31:0]  word;

`ifdef INSTR_ENC_LEGAL_CHECK_EN
   function automatic logic is_illegal(
      input logic [2:0]  t,
      input logic [2:0]  f3,
      input logic        alt,
      input logic [31:0] imm
   );
      logic sext12, sext13, sext21, shift, bad;
      sext12 = (&imm[31:11]) || !(|imm[31:11]);
      sext13 = (&imm[31:12]) || !(|imm[31:12]);
      sext21 = (&imm[31:20]) || !(|imm[31:20]);
      shift  = (f3 == 3'b001) || (f3 == 3'b101);
      case (t)
         3'd0: bad = alt && !(f3 == 3'b000 || f3 == 3'b101);
         3'd1: bad = shift ? (imm[31:5] != 27'd0) : !sext12;
         3'd2: bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || !sext12;
         3'd3: bad = (f3 > 3'd2) || !sext12;
         3'd4: bad = (f3 == 3'd2) || (f3 == 3'd3) || imm[0] || !sext13;
         3'd5: bad = 1'b0;
         3'd6: bad = imm[0] || !sext21;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   logic err_q, err_d;

   assign illegal = is_illegal(req_type, req_func3, req_alt, req_imm);
   assign err_d   = accept && illegal;
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end
`else
   assign illegal = 1'b0;
   assign err     = 1'b0;
`endif

   assign word        = encode(req_type, req_func3, req_alt, req_rd, req_rs1, req_rs2, req_imm);
   assign req_ready   = !reset && (count_q != FULL_CNT);
   assign instr_valid = (count_q != '0);
   assign accept      = req_valid && req_ready;
   assign push        = accept && !illegal;
   assign pop         = instr_valid && instr_ready;
   assign instruction = instr_valid ? mem_q[rd_q] : 32'd0;
   assign count       = count_q;

   always_comb begin
      wr_d    = push ? wr_q + PW'(1) : wr_q;
      rd_d    = pop  ? rd_q + PW'(1) : rd_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Storage holds data only; validity comes from count_q, so no reset needed.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= word;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued at accept, compared at pop.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_type = '0;
   logic [2:0]  req_func3 = '0;
   logic        req_alt = 1'b0;
   logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
   logic [31:0] req_imm = '0;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        err;
   logic [2:0]  count;

   logic [31:0] sb [$];
   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_type(req_type), .req_func3(req_func3), .req_alt(req_alt),
      .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
      .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .err(err), .count(count)
   );

   // Pops happen at the next rising edge whenever valid && ready at the falling edge.
   always @(negedge clk) begin
      if (!reset && instr_valid && instr_ready) begin
         chk_cnt++;
         if (sb.size() == 0)
            $display("FAIL sb_unexpected: got %h, required no output", instruction);
         else begin
            logic [31:0] exp_w;
            exp_w = sb.pop_front();
            if (instruction !== exp_w)
               $display("FAIL sb_word: got %h, required %h", instruction, exp_w);
            else
               pass_cnt++;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge, req_valid left high.
   task automatic send(input logic [2:0] t, input logic [2:0] f3, input logic alt,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic [31:0] exp_w, input bit push);
      int n;
      n = 0;
      req_valid = 1'b1; req_type = t; req_func3 = f3; req_alt = alt;
      req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk_cnt++;
         $display("FAIL send_timeout: req_ready=%b, required 1", req_ready);
      end else if (push) sb.push_back(exp_w);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      instr_ready = 1'b1;
      @(negedge clk);
      while (count != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk_cnt++;
      if (count !== 3'd0 || sb.size() != 0)
         $display("FAIL %s_drain: count=%0d left=%0d, required 0/0", name, count, sb.size());
      else pass_cnt++;
      @(posedge clk);
      #1 instr_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_cnt++;
      if (instr_valid !== 1'b0 || instruction !== 32'd0 || count !== 3'd0 || err !== 1'b0 || req_ready !== 1'b0)
         $display("FAIL reset_state: valid=%b instr=%h count=%0d err=%b ready=%b, required 0", instr_valid, instruction, count, err, req_ready);
      else pass_cnt++;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", req_ready);
      else pass_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_r_type;
      send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b1);
      chk_cnt++;
      if (instr_valid !== 1'b1 || instruction !== 32'h002081B3 || count !== 3'd1)
         $display("FAIL r_latency: valid=%b instr=%h count=%0d, required 1/002081b3/1", instr_valid, instruction, count);
      else pass_cnt++;
      send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b1);
      req_valid = 1'b0;
      chk_cnt++;
      if (count !== 3'd2 || instruction !== 32'h002081B3)
         $display("FAIL r_second: count=%0d head=%h, required 2/002081b3", count, instruction);
      else pass_cnt++;
      drain("r");
   endtask

   task automatic test_l_b;
      instr_ready = 1'b1;
      send(3'd2, 3'd2, 1'b0, 5'd5, 5'd1, 5'd0, 32'd8, 32'h0080A283, 1'b1);
      send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b1);
      req_valid = 1'b0;
      drain("lb");
   endtask

   task automatic test_back_to_back;
      instr_ready = 1'b1;
      send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF, 1'b1);
      chk_cnt++;
      if (instr_valid !== 1'b1 || instruction !== 32'h001000EF)
         $display("FAIL b2b_first: valid=%b instr=%h, required 1/001000ef", instr_valid, instruction);
      else pass_cnt++;
      send(3'd5, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h12345000, 32'h123453B7, 1'b1);
      req_valid = 1'b0;
      chk_cnt++;
      if (instr_valid !== 1'b1 || instruction !== 32'h123453B7 || count !== 3'd1)
         $display("FAIL b2b_second: valid=%b instr=%h count=%0d, required 1/123453b7/1", instr_valid, instruction, count);
      else pass_cnt++;
      drain("b2b");
   endtask

   task automatic test_full;
      instr_ready = 1'b0;
      send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b1);
      send(3'd2, 3'd2, 1'b0, 5'd5, 5'd1, 5'd0, 32'd8, 32'h0080A283, 1'b1);
      send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF, 1'b1);
      send(3'd5, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h12345000, 32'h123453B7, 1'b1);
      req_type = 3'd0; req_alt = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (req_ready !== 1'b0 || count !== 3'd4)
         $display("FAIL full_block: ready=%b count=%0d, required 0/4", req_ready, count);
      else pass_cnt++;
      @(posedge clk);
      #1;
      chk_cnt++;
      if (count !== 3'd4 || instruction !== 32'h002081B3)
         $display("FAIL full_hold: count=%0d head=%h, required 4/002081b3", count, instruction);
      else pass_cnt++;
      req_valid = 1'b0;
      instr_ready = 1'b1;
      @(posedge clk);
      #1;
      chk_cnt++;
      if (count !== 3'd3 || req_ready !== 1'b1)
         $display("FAIL full_reopen: count=%0d ready=%b, required 3/1", count, req_ready);
      else pass_cnt++;
      drain("full");
   endtask

   task automatic test_illegal;
      instr_ready = 1'b0;
`ifdef INSTR_ENC_LEGAL_CHECK_EN
      send(3'd2, 3'd3, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
      req_valid = 1'b0;
      chk_cnt++;
      if (err !== 1'b1 || count !== 3'd0)
         $display("FAIL illegal_err: err=%b count=%0d, required 1/0", err, count);
      else pass_cnt++;
      @(posedge clk);
      #1;
      chk_cnt++;
      if (err !== 1'b0) $display("FAIL illegal_pulse: err=%b, required 0", err);
      else pass_cnt++;
      send(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
      req_valid = 1'b0;
      chk_cnt++;
      if (err !== 1'b1 || count !== 3'd0)
         $display("FAIL reserved_err: err=%b count=%0d, required 1/0", err, count);
      else pass_cnt++;
`else
      send(3'd2, 3'd3, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 32'h00003083, 1'b1);
      req_valid = 1'b0;
      chk_cnt++;
      if (err !== 1'b0 || count !== 3'd1 || instruction !== 32'h00003083)
         $display("FAIL nocheck_l: err=%b count=%0d instr=%h, required 0/1/00003083", err, count, instruction);
      else pass_cnt++;
      send(3'd7, 3'd0, 1'b0, 5'd9, 5'd9, 5'd9, 32'hFFFF_FFFF, 32'h00000013, 1'b1);
      req_valid = 1'b0;
      chk_cnt++;
      if (err !== 1'b0 || count !== 3'd2)
         $display("FAIL nocheck_nop: err=%b count=%0d, required 0/2", err, count);
      else pass_cnt++;
`endif
      drain("illegal");
   endtask

   task automatic test_reset_mid;
      instr_ready = 1'b0;
      send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b1);
      send(3'd2, 3'd2, 1'b0, 5'd5, 5'd1, 5'd0, 32'd8, 32'h0080A283, 1'b1);
      send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b1);
      req_valid = 1'b0;
      chk_cnt++;
      if (count !== 3'd3) $display("FAIL mid_fill: count=%0d, required 3", count);
      else pass_cnt++;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      sb.delete();
      chk_cnt++;
      if (count !== 3'd0 || instr_valid !== 1'b0 || instruction !== 32'd0)
         $display("FAIL mid_flush: count=%0d valid=%b instr=%h, required 0/0/0", count, instr_valid, instruction);
      else pass_cnt++;
      send(3'd5, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h12345000, 32'h123453B7, 1'b1);
      req_valid = 1'b0;
      chk_cnt++;
      if (instr_valid !== 1'b1 || instruction !== 32'h123453B7 || count !== 3'd1)
         $display("FAIL mid_after: valid=%b instr=%h count=%0d, required 1/123453b7/1", instr_valid, instruction, count);
      else pass_cnt++;
      drain("mid");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_r_type();
      test_l_b();
      test_back_to_back();
      test_full();
      test_illegal();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
